// File: rtl/led_pattern_gen.sv
// LED pattern generator: debounced mode/hold buttons select COUNT, SCAN or
// BREATHE patterns stepped by a prescaled tick.

module led_btn_debounce #(
    parameter int CYCLES = 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_level
);
    localparam int CW = $clog2(CYCLES + 1);
    localparam logic [CW-1:0] RUN_LAST = CW'(CYCLES - 1);

    logic [1:0]    sync;
    logic [CW-1:0] run;

    // run counts consecutive cycles where the synchronised level disagrees
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync    <= '0;
            run     <= '0;
            o_level <= 1'b0;
        end else begin
            sync <= {sync[0], i_btn};
            if (sync[1] == o_level) begin
                run <= '0;
            end else if (run == RUN_LAST) begin
                o_level <= sync[1];
                run     <= '0;
            end else begin
                run <= run + 1'b1;
            end
        end
    end
endmodule

// state        | meaning
// MODE_COUNT   | binary counter on the LEDs
// MODE_SCAN    | single lit LED bouncing between the ends
// MODE_BREATHE | all LEDs PWM-dimmed, duty ramping up and down
// MODE_ILLEGAL | unreachable; recovers to MODE_COUNT next cycle
module led_pattern_gen #(
    parameter int NUM_LEDS        = 8,
    parameter int TICK_DIV        = 262144,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int PWM_BITS        = 8
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_btn_mode,
    input  logic                i_btn_hold,
    output logic [NUM_LEDS-1:0] o_led,
    output logic [1:0]          o_mode,
    output logic                o_tick
);
    localparam int PRE_W = $clog2(TICK_DIV);
    localparam int IDX_W = $clog2(NUM_LEDS);
    localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(NUM_LEDS - 1);
    localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;

    typedef enum logic [1:0] {
        MODE_COUNT   = 2'd0,
        MODE_SCAN    = 2'd1,
        MODE_BREATHE = 2'd2,
        MODE_ILLEGAL = 2'd3
    } mode_t;

    mode_t               mode;
    logic                mode_lvl;
    logic                hold_lvl;
    logic                mode_prev;
    logic                press;
    logic                tick;
    logic [PRE_W-1:0]    presc;
    logic [NUM_LEDS-1:0] count;
    logic [IDX_W-1:0]    scan_idx;
    logic                scan_down;
    logic [PWM_BITS-1:0] pwm_ctr;
    logic [PWM_BITS-1:0] duty;
    logic                duty_down;
    logic [NUM_LEDS-1:0] led_next;

    led_btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_deb_mode (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_btn   (i_btn_mode),
        .o_level (mode_lvl)
    );

    led_btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_deb_hold (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_btn   (i_btn_hold),
        .o_level (hold_lvl)
    );

    assign press  = mode_lvl & ~mode_prev;
    assign tick   = (presc == PRE_LAST) && !hold_lvl;
    assign o_tick = tick;
    assign o_mode = mode;

    always_comb begin
        led_next = '0;
        case (mode)
            MODE_COUNT:   led_next = count;
            MODE_SCAN:    led_next = {{(NUM_LEDS-1){1'b0}}, 1'b1} << scan_idx;
            MODE_BREATHE: led_next = {NUM_LEDS{pwm_ctr < duty}};
            default:      led_next = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mode      <= MODE_COUNT;
            mode_prev <= 1'b0;
            presc     <= '0;
            count     <= '0;
            scan_idx  <= '0;
            scan_down <= 1'b0;
            pwm_ctr   <= '0;
            duty      <= '0;
            duty_down <= 1'b0;
            o_led     <= '0;
        end else begin
            o_led     <= led_next;
            mode_prev <= mode_lvl;
            pwm_ctr   <= pwm_ctr + 1'b1;
            // a mode change overrides any tick landing in the same cycle
            if (press || mode == MODE_ILLEGAL) begin
                case (mode)
                    MODE_COUNT: mode <= MODE_SCAN;
                    MODE_SCAN:  mode <= MODE_BREATHE;
                    default:    mode <= MODE_COUNT;
                endcase
                presc     <= '0;
                count     <= '0;
                scan_idx  <= '0;
                scan_down <= 1'b0;
                duty      <= '0;
                duty_down <= 1'b0;
            end else if (!hold_lvl) begin
                presc <= (presc == PRE_LAST) ? '0 : presc + 1'b1;
                if (tick) begin
                    count <= count + 1'b1;
                    if (!scan_down) begin
                        if (scan_idx == IDX_LAST) begin
                            scan_idx  <= scan_idx - 1'b1;
                            scan_down <= 1'b1;
                        end else begin
                            scan_idx <= scan_idx + 1'b1;
                        end
                    end else if (scan_idx == '0) begin
                        scan_idx  <= IDX_W'(1);
                        scan_down <= 1'b0;
                    end else begin
                        scan_idx <= scan_idx - 1'b1;
                    end
                    if (!duty_down) begin
                        if (duty == DUTY_MAX) begin
                            duty      <= duty - 1'b1;
                            duty_down <= 1'b1;
                        end else begin
                            duty <= duty + 1'b1;
                        end
                    end else if (duty == '0) begin
                        duty      <= PWM_BITS'(1);
                        duty_down <= 1'b0;
                    end else begin
                        duty <= duty - 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: directed steps plus random button activity,
// checked every cycle against a phase-based reference model.

module tb_led_pattern_gen;
    localparam int N = 4;
    localparam int T = 4;
    localparam int D = 3;
    localparam int P = 3;
    localparam int SCAN_PER = 2 * (N - 1);
    localparam int BR_PER   = 2 * ((1 << P) - 1);

    logic         i_clk = 1'b0;
    logic         i_rst_n = 1'b1;
    logic         i_btn_mode = 1'b0;
    logic         i_btn_hold = 1'b0;
    logic [N-1:0] o_led;
    logic [1:0]   o_mode;
    logic         o_tick;

    int n_assert = 0;
    int n_fail   = 0;

    led_pattern_gen #(
        .NUM_LEDS(N), .TICK_DIV(T), .DEBOUNCE_CYCLES(D), .PWM_BITS(P)
    ) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_btn_mode (i_btn_mode),
        .i_btn_hold (i_btn_hold),
        .o_led      (o_led),
        .o_mode     (o_mode),
        .o_tick     (o_tick)
    );

    always #5 i_clk = ~i_clk;

    // reference model: patterns tracked as phases within their period
    bit           ms0, ms1, hs0, hs1, m_mlvl, m_hlvl, m_mprev;
    int           m_mrun, m_hrun;
    int           m_mode, m_presc, m_count, m_scan, m_br, m_pwm;
    logic [N-1:0] m_led;

    task automatic model_reset();
        ms0 = 0; ms1 = 0; hs0 = 0; hs1 = 0;
        m_mlvl = 0; m_hlvl = 0; m_mprev = 0; m_mrun = 0; m_hrun = 0;
        m_mode = 0; m_presc = 0; m_count = 0; m_scan = 0; m_br = 0; m_pwm = 0;
        m_led = '0;
    endtask

    function automatic logic [N-1:0] model_led();
        int pos, duty;
        logic [N-1:0] one;
        one = 1;
        case (m_mode)
            0: return N'(m_count);
            1: begin
                pos = (m_scan < N) ? m_scan : SCAN_PER - m_scan;
                return one << pos;
            end
            2: begin
                duty = (m_br < (1 << P)) ? m_br : BR_PER - m_br;
                return (m_pwm < duty) ? '1 : '0;
            end
            default: return '0;
        endcase
    endfunction

    task automatic model_step();
        bit press, tick, hold_old;
        logic [N-1:0] led_n;
        press    = m_mlvl && !m_mprev;
        hold_old = m_hlvl;
        tick     = (m_presc == T - 1) && !hold_old;
        led_n    = model_led();
        m_mprev  = m_mlvl;
        if (ms1 == m_mlvl) m_mrun = 0;
        else begin
            m_mrun++;
            if (m_mrun == D) begin m_mlvl = ms1; m_mrun = 0; end
        end
        if (hs1 == m_hlvl) m_hrun = 0;
        else begin
            m_hrun++;
            if (m_hrun == D) begin m_hlvl = hs1; m_hrun = 0; end
        end
        ms1 = ms0; ms0 = i_btn_mode;
        hs1 = hs0; hs0 = i_btn_hold;
        if (press) begin
            m_mode  = (m_mode + 1) % 3;
            m_presc = 0; m_count = 0; m_scan = 0; m_br = 0;
        end else if (!hold_old) begin
            m_presc = (m_presc + 1) % T;
            if (tick) begin
                m_count = (m_count + 1) % (1 << N);
                m_scan  = (m_scan + 1) % SCAN_PER;
                m_br    = (m_br + 1) % BR_PER;
            end
        end
        m_pwm = (m_pwm + 1) % (1 << P);
        m_led = led_n;
    endtask

    task automatic chk(input string tag);
        logic exp_tick;
        exp_tick = (m_presc == T - 1) && !m_hlvl;
        n_assert++;
        assert (o_led === m_led) else begin
            n_fail++;
            $error("FAIL %s led: observed %b expected %b", tag, o_led, m_led);
        end
        n_assert++;
        assert (o_mode === 2'(m_mode)) else begin
            n_fail++;
            $error("FAIL %s mode: observed %0d expected %0d", tag, o_mode, m_mode);
        end
        n_assert++;
        assert (o_tick === exp_tick) else begin
            n_fail++;
            $error("FAIL %s tick: observed %b expected %b", tag, o_tick, exp_tick);
        end
    endtask

    task automatic cycle(input string tag);
        @(posedge i_clk);
        model_step();
        @(negedge i_clk);
        chk(tag);
    endtask

    task automatic cycles(input string tag, input int n);
        for (int i = 0; i < n; i++) cycle(tag);
    endtask

    task automatic direct(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic press_mode(input string tag);
        i_btn_mode = 1'b1;
        cycles(tag, 8);
        i_btn_mode = 1'b0;
        cycles(tag, 8);
    endtask

    initial begin
        int guard;
        int seg_len;

        model_reset();
        #2 i_rst_n = 1'b0;
        #1;
        direct("reset_led", o_led, 4'b0000);
        direct("reset_mode", {2'b00, o_mode}, 4'd0);
        direct("reset_tick", {3'b000, o_tick}, 4'd0);
        @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        cycles("count", 2);
        cycle("count");
        direct("first_tick", {3'b000, o_tick}, 4'd1);
        cycles("count", 70);

        i_btn_mode = 1'b1;
        cycles("short_press", 2);
        i_btn_mode = 1'b0;
        cycles("short_press", 8);
        direct("short_press_mode", {2'b00, o_mode}, 4'd0);

        i_btn_mode = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            cycle("long_press");
            if (k == 5) direct("mode_before_6", {2'b00, o_mode}, 4'd0);
            if (k == 6) direct("mode_at_6", {2'b00, o_mode}, 4'd1);
            if (k == 7) direct("scan_start_led", o_led, 4'b0001);
        end
        i_btn_mode = 1'b0;
        cycles("scan", 40);

        press_mode("to_breathe");
        cycles("breathe", 120);
        press_mode("to_count");

        guard = 0;
        while (!(m_mode == 0 && m_count == 4 && m_presc == 2) && guard < 200) begin
            cycle("seek_hold");
            guard++;
        end
        n_assert++;
        assert (guard < 200) else begin
            n_fail++;
            $error("FAIL seek_hold: observed %0d cycles expected < 200", guard);
        end
        i_btn_hold = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            cycle("hold");
            if (k == 20) begin
                direct("hold_led", o_led, 4'b0101);
                direct("hold_tick", {3'b000, o_tick}, 4'd0);
            end
        end
        i_btn_hold = 1'b0;
        for (int k = 1; k <= 8; k++) cycle("hold_release");
        direct("resume_led", o_led, 4'b0110);
        cycles("count", 10);

        guard = 0;
        while (!(m_mode == 0 && m_count == 2 && m_presc == 2) && guard < 200) begin
            cycle("seek_collide");
            guard++;
        end
        n_assert++;
        assert (guard < 200) else begin
            n_fail++;
            $error("FAIL seek_collide: observed %0d cycles expected < 200", guard);
        end
        i_btn_mode = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            cycle("collide");
            if (k == 5) begin
                direct("collide_tick", {3'b000, o_tick}, 4'd1);
                direct("collide_led_before", o_led, 4'b0011);
            end
            if (k == 6) direct("collide_mode", {2'b00, o_mode}, 4'd1);
            if (k == 7) direct("collide_led_after", o_led, 4'b0001);
        end
        i_btn_mode = 1'b0;
        cycles("collide", 8);

        for (int s = 0; s < 40; s++) begin
            i_btn_mode = 1'($urandom_range(0, 1));
            i_btn_hold = 1'($urandom_range(0, 1));
            seg_len    = int'($urandom_range(1, 12));
            cycles("random", seg_len);
        end
        i_btn_mode = 1'b0;
        i_btn_hold = 1'b0;
        cycles("settle", 12);

        for (int p = 0; p < 3; p++) begin
            if (m_mode != 1) press_mode("seek_scan");
        end
        direct("scan_before_reset", {2'b00, o_mode}, 4'd1);
        cycles("scan", 7);
        #2 i_rst_n = 1'b0;
        #1;
        direct("async_reset_led", o_led, 4'b0000);
        direct("async_reset_mode", {2'b00, o_mode}, 4'd0);
        direct("async_reset_tick", {3'b000, o_tick}, 4'd0);
        model_reset();
        @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        cycles("restart", 2);
        cycle("restart");
        direct("restart_tick", {3'b000, o_tick}, 4'd1);
        cycles("restart", 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/led_pattern_gen.md
LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 Parameter NUM_LEDS, default 8, LED count (>=2).
REQ-002 Parameter TICK_DIV, default 262144, clock cycles per pattern tick (>=2).
REQ-003 Parameter DEBOUNCE_CYCLES, default 250000, consecutive stable samples required to accept a button level (>=1).
REQ-004 Parameter PWM_BITS, default 8, PWM counter and duty width.
REQ-005 i_clk  in  1  system clock, 25 MHz on ULX3S.
REQ-006 i_rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-007 i_btn_mode  in  1  raw asynchronous button; press (0->1) advances display mode.
REQ-008 i_btn_hold  in  1  raw asynchronous button; level 1 freezes the pattern.
REQ-009 o_led  out  NUM_LEDS  registered LED drive, 1 = lit.
REQ-010 o_mode  out  2  current mode: 0 COUNT, 1 SCAN, 2 BREATHE.
REQ-011 o_tick  out  1  single-cycle tick strobe.

Function
REQ-012 Each button SHALL pass through a 2-flop synchroniser, then a debouncer whose accepted level changes only after the synchronised level has differed from it for DEBOUNCE_CYCLES consecutive cycles; any mismatch-free cycle restarts the count.
REQ-013 A mode press SHALL be a 0->1 transition of the debounced mode level; release SHALL have no effect.
REQ-014 Mode SHALL advance COUNT->SCAN->BREATHE->COUNT on each press; encoding 3 SHALL be unreachable and, if present, SHALL return to COUNT on the next cycle.
REQ-015 o_mode SHALL change on the edge following the debounced-level change, i.e. 2+DEBOUNCE_CYCLES+1 cycles after a clean raw rising edge.
REQ-016 Prescaler SHALL count 0..TICK_DIV-1 and wrap; o_tick SHALL be 1 for exactly the cycle in which the prescaler equals TICK_DIV-1.
REQ-017 While debounced hold = 1, prescaler and all pattern state SHALL freeze and o_tick SHALL stay 0; PWM counter keeps running.
REQ-018 COUNT: NUM_LEDS-bit pattern SHALL increment by 1 per tick, wrapping all-ones -> 0.
REQ-019 SCAN: one-hot position SHALL move one step toward MSB per tick, reverse at bit NUM_LEDS-1, move toward LSB, reverse at bit 0; period 2*(NUM_LEDS-1) ticks, each end lit for one tick.
REQ-020 BREATHE: free-running PWM_BITS counter increments every cycle; duty SHALL step +1 per tick from 0 to 2^PWM_BITS-1, then -1 per tick to 0, then repeat; all LEDs = (pwm_ctr < duty), so duty 0 = fully dark.
REQ-021 On a mode change, prescaler, count pattern, scan position (bit 0, direction up) and duty (0, direction up) SHALL all clear in the same cycle.
REQ-022 Press and tick in the same cycle: the mode change SHALL win; that tick's pattern update is discarded; o_tick still pulses.
REQ-023 o_led SHALL be registered, reflecting pattern state with one cycle of latency.
REQ-024 Arithmetic SHALL be modulo register width, with no overflow flags.

Reset
REQ-025 Asserting i_rst_n = 0 SHALL immediately, independent of i_clk: set o_led = 0, o_mode = 0, o_tick = 0; clear synchronisers, debounce counters and debounced levels (to 0), prescaler, PWM counter, duty, direction, count pattern, and scan position (bit 0, up).
REQ-026 Reset asserted mid-debounce or mid-pattern SHALL discard all progress; after release, operation restarts from REQ-025 state on the first clock edge.

Verification (NUM_LEDS=4, TICK_DIV=4, DEBOUNCE_CYCLES=3, PWM_BITS=3)
REQ-027 Reset release, no buttons -> o_tick pulses every 4 cycles; o_led goes 0001, 0010, 0011 ... 1111, 0000, one cycle after each tick.
REQ-028 Mode pulse held 2 cycles, then released -> no mode change; held 10 cycles -> o_mode = 1 exactly 6 cycles after the raw edge, and o_led = 0001.
REQ-029 In SCAN -> o_led sequence 0001, 0010, 0100, 1000, 0100, 0010, 0001, one step per tick.
REQ-030 BREATHE at duty 3 -> o_led = 1111 for 3 of every 8 cycles; duty sequence 0..7..0 across ticks.
REQ-031 Hold = 1 for 40 cycles in COUNT at 0101 -> o_tick stays 0, o_led stays 0101; after hold releases, counting resumes at 0110.
REQ-032 Mode press coinciding with a tick in COUNT at 0011 -> o_mode = 1 and o_led = 0001, not 0100; asynchronous reset mid-SCAN -> o_led = 0 and o_mode = 0 immediately.
